// File: rtl/bmem_arbiter.sv
// Round-robin arbiter sharing one banked-memory port among cache requesters.
// Define BMEM_ARB_PERF_EN to add per-requester grant/stall counters.
module bmem_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_OUTST = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_read,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*64-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ*32-1:0] req_raddr,
  output logic [NUM_REQ*64-1:0] req_rdata,
  output logic [NUM_REQ-1:0]    req_rvalid,
  output logic [31:0]           bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [63:0]           bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [31:0]           bmem_raddr,
  input  logic [63:0]           bmem_rdata,
  input  logic                  bmem_rvalid
`ifdef BMEM_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0] perf_grant,
  output logic [NUM_REQ*32-1:0] perf_stall
`endif
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW = $clog2(MAX_OUTST);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  typedef enum logic {IDLE, WR_BURST} state_e;

  state_e               state_q, state_d;
  logic [OW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [MAX_OUTST-1:0] tv_q, tv_d;
  logic [31:0]          ta_q [MAX_OUTST];
  logic [31:0]          ta_d [MAX_OUTST];
  logic [OW-1:0]        to_q [MAX_OUTST];
  logic [OW-1:0]        to_d [MAX_OUTST];
  logic [CW-1:0]        tc_q [MAX_OUTST];
  logic [CW-1:0]        tc_d [MAX_OUTST];
  logic                 err_q, err_d;

  logic                 rsp_hit, rsp_fire, rsp_last;
  logic [IW-1:0]        rsp_idx;
  logic [MAX_OUTST-1:0] tv_live;
  logic                 full;
  logic [IW-1:0]        free_idx;
  logic [NUM_REQ-1:0]   addr_hit, elig;
  logic                 gnt_vld;
  logic [OW-1:0]        gnt, cand, sel;
  logic [31:0]          s_addr;
  logic [63:0]          s_wdata;
  logic                 s_write;

  // Response CAM; a finishing entry is freed before allocation sees it.
  always_comb begin
    rsp_hit = 1'b0;
    rsp_idx = '0;
    for (int e = 0; e < MAX_OUTST; e++) begin
      if (!rsp_hit && tv_q[e] && ta_q[e] == bmem_raddr) begin
        rsp_hit = 1'b1;
        rsp_idx = IW'(e);
      end
    end
    rsp_fire = rst_n & bmem_rvalid & rsp_hit;
    rsp_last = tc_q[rsp_idx] == LAST;
    tv_live  = tv_q;
    if (rsp_fire && rsp_last) tv_live[rsp_idx] = 1'b0;
  end

  always_comb begin
    req_rvalid = '0;
    req_raddr  = '0;
    req_rdata  = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (rsp_fire && to_q[rsp_idx] == OW'(r)) begin
        req_rvalid[r]        = 1'b1;
        req_raddr[r*32 +: 32] = bmem_raddr;
        req_rdata[r*64 +: 64] = bmem_rdata;
      end
    end
  end

  always_comb begin
    full     = &tv_live;
    free_idx = '0;
    for (int e = MAX_OUTST - 1; e >= 0; e--) begin
      if (!tv_live[e]) free_idx = IW'(e);
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      addr_hit[r] = 1'b0;
      for (int e = 0; e < MAX_OUTST; e++) begin
        if (tv_live[e] && ta_q[e] == req_addr[r*32 +: 32]) addr_hit[r] = 1'b1;
      end
      elig[r] = req_write[r] | (req_read[r] & ~full & ~addr_hit[r]);
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = OW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt     = cand;
      end
    end
  end

  always_comb begin
    sel     = (state_q == WR_BURST) ? owner_q : gnt;
    s_addr  = '0;
    s_wdata = '0;
    s_write = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (OW'(r) == sel) begin
        s_addr  = req_addr[r*32 +: 32];
        s_wdata = req_wdata[r*64 +: 64];
        s_write = req_write[r];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    tv_d       = tv_live;
    ta_d       = ta_q;
    to_d       = to_q;
    tc_d       = tc_q;
    err_d      = err_q | (rst_n & bmem_rvalid & ~rsp_hit);
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    req_ready  = '0;
    if (rsp_fire) tc_d[rsp_idx] = rsp_last ? '0 : tc_q[rsp_idx] + 1'b1;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            bmem_addr  = s_addr;
            bmem_write = s_write;
            bmem_read  = ~s_write;
            bmem_wdata = s_write ? s_wdata : '0;
            if (bmem_ready) begin
              req_ready[gnt] = 1'b1;
              rr_ptr_d = (gnt == OW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
              if (s_write) begin
                if (BURST_LEN > 1) begin
                  state_d    = WR_BURST;
                  owner_d    = gnt;
                  beat_cnt_d = CW'(1);
                end
              end else begin
                tv_d[free_idx] = 1'b1;
                ta_d[free_idx] = s_addr;
                to_d[free_idx] = gnt;
                tc_d[free_idx] = '0;
              end
            end
          end
        end
        WR_BURST: begin
          bmem_addr  = s_addr;
          bmem_write = s_write;
          bmem_wdata = s_wdata;
          if (s_write && bmem_ready) begin
            req_ready[owner_q] = 1'b1;
            if (beat_cnt_q == LAST) begin
              state_d    = IDLE;
              beat_cnt_d = '0;
            end else begin
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      tv_q       <= '0;
      err_q      <= 1'b0;
      for (int e = 0; e < MAX_OUTST; e++) begin
        ta_q[e] <= '0;
        to_q[e] <= '0;
        tc_q[e] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      tv_q       <= tv_d;
      err_q      <= err_d;
      ta_q       <= ta_d;
      to_q       <= to_d;
      tc_q       <= tc_d;
    end
  end

  a_rsp_known: assert property (@(posedge clk) disable iff (!rst_n)
    bmem_rvalid |-> rsp_hit);

`ifdef BMEM_ARB_PERF_EN
  logic [31:0] grant_cnt_q [NUM_REQ];
  logic [31:0] grant_cnt_d [NUM_REQ];
  logic [31:0] stall_cnt_q [NUM_REQ];
  logic [31:0] stall_cnt_d [NUM_REQ];

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      grant_cnt_d[r] = grant_cnt_q[r] + {31'b0, req_ready[r]};
      stall_cnt_d[r] = stall_cnt_q[r]
                     + {31'b0, (req_read[r] | req_write[r]) & ~req_ready[r]};
      perf_grant[r*32 +: 32] = grant_cnt_q[r];
      perf_stall[r*32 +: 32] = stall_cnt_q[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        grant_cnt_q[r] <= '0;
        stall_cnt_q[r] <= '0;
      end
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_bmem_arbiter.sv
// Bench for bmem_arbiter: directed scenarios plus randomized traffic,
// all cycles checked against a queue-based behavioural model.
module tb_bmem_arbiter;
  localparam int N  = 2;
  localparam int M  = 4;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N*32-1:0] req_addr;
  logic [N-1:0]  req_read, req_write;
  logic [N*64-1:0] req_wdata;
  logic [N-1:0]  req_ready, req_rvalid;
  logic [N*32-1:0] req_raddr;
  logic [N*64-1:0] req_rdata;
  logic [31:0]   bmem_addr, bmem_raddr;
  logic          bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0]   bmem_wdata, bmem_rdata;
`ifdef BMEM_ARB_PERF_EN
  logic [N*32-1:0] perf_grant, perf_stall;
`endif

  always #5 clk = ~clk;

  bmem_arbiter #(.NUM_REQ(N), .MAX_OUTST(M), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr), .req_read(req_read), .req_write(req_write),
    .req_wdata(req_wdata), .req_ready(req_ready), .req_raddr(req_raddr),
    .req_rdata(req_rdata), .req_rvalid(req_rvalid),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
`ifdef BMEM_ARB_PERF_EN
    , .perf_grant(perf_grant), .perf_stall(perf_stall)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: outstanding reads as a queue of {addr, owner, beats seen}.
  typedef struct {
    logic [31:0] a;
    int          o;
    int          c;
  } ent_t;

  ent_t        m_tab[$];
  bit          m_burst = 0;
  int          m_owner = 0;
  int          m_beats = 0;
  int          m_rr    = 0;
  logic [N-1:0] m_rdy_last = '0;

  always @(negedge clk) begin : model
    ent_t t2[$];
    ent_t tmp;
    logic [N-1:0] e_rdy, e_rv;
    logic [N*32-1:0] e_ra, mra;
    logic [N*64-1:0] e_rd, mrd;
    logic e_br, e_bw;
    logic [31:0] e_a;
    logic [63:0] e_wd;
    int hit, g, i;
    bit el, busy;
    e_rdy = '0; e_rv = '0; e_ra = '0; e_rd = '0; mra = '0; mrd = '0;
    e_br = 0; e_bw = 0; e_a = '0; e_wd = '0;
    t2.delete();
    if (!rst_n) begin
      m_burst = 0; m_beats = 0; m_rr = 0;
      mra = '1; mrd = '1;
    end else begin
      hit = -1;
      if (bmem_rvalid)
        foreach (m_tab[k]) if (m_tab[k].a == bmem_raddr) hit = k;
      t2 = m_tab;
      if (hit >= 0) begin
        g = m_tab[hit].o;
        e_rv[g] = 1'b1;
        e_ra[g*32 +: 32] = bmem_raddr;
        e_rd[g*64 +: 64] = bmem_rdata;
        mra[g*32 +: 32] = '1;
        mrd[g*64 +: 64] = '1;
        tmp = t2[hit];
        tmp.c++;
        t2[hit] = tmp;
        if (tmp.c == BL) t2.delete(hit);
      end
      if (!m_burst) begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          i = (m_rr + k) % N;
          busy = 0;
          foreach (t2[j]) if (t2[j].a == req_addr[i*32 +: 32]) busy = 1;
          el = req_write[i] || (req_read[i] && t2.size() < M && !busy);
          if (el && g < 0) g = i;
        end
        if (g >= 0) begin
          e_a  = req_addr[g*32 +: 32];
          e_bw = req_write[g];
          e_br = !req_write[g];
          e_wd = req_wdata[g*64 +: 64];
          if (bmem_ready) begin
            e_rdy[g] = 1'b1;
            m_rr = (g + 1) % N;
            if (req_write[g]) begin
              m_burst = 1; m_owner = g; m_beats = 1;
            end else begin
              t2.push_back('{a: e_a, o: g, c: 0});
            end
          end
        end
      end else begin
        e_a  = req_addr[m_owner*32 +: 32];
        e_bw = req_write[m_owner];
        e_wd = req_wdata[m_owner*64 +: 64];
        if (e_bw && bmem_ready) begin
          e_rdy[m_owner] = 1'b1;
          m_beats++;
          if (m_beats == BL) m_burst = 0;
        end
      end
    end
    chk("req_ready", req_ready, e_rdy);
    chk("req_rvalid", req_rvalid, e_rv);
    chk("req_raddr", req_raddr & mra, e_ra);
    chk("req_rdata", req_rdata & mrd, e_rd);
    chk("bmem_read", bmem_read, e_br);
    chk("bmem_write", bmem_write, e_bw);
    if (e_br || e_bw || !rst_n) chk("bmem_addr", bmem_addr, e_a);
    if (e_bw || !rst_n) chk("bmem_wdata", bmem_wdata, e_wd);
    m_tab = t2;
    m_rdy_last = e_rdy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_read = '0; req_write = '0; bmem_rvalid = 1'b0;
  endtask

  task automatic ret(logic [31:0] a);
    for (int b = 0; b < BL; b++) begin
      step();
      bmem_rvalid = 1'b1;
      bmem_raddr  = a;
      bmem_rdata  = {$urandom, $urandom};
    end
    step();
    bmem_rvalid = 1'b0;
  endtask

  logic [31:0] pool [6] = '{32'h1000, 32'h2000, 32'h3000,
                            32'h4000, 32'h5000, 32'h6000};
  int rd_pend [N];
  int wr_left [N];

  task automatic rnd_cycle();
    int r;
    for (int i = 0; i < N; i++) begin
      if (rd_pend[i] != 0 && m_rdy_last[i]) rd_pend[i] = 0;
      if (wr_left[i] > 0 && m_rdy_last[i]) wr_left[i]--;
      if (rd_pend[i] == 0 && wr_left[i] == 0) begin
        r = $urandom_range(0, 7);
        if (r < 3) begin
          rd_pend[i] = 1;
          req_addr[i*32 +: 32] = pool[$urandom_range(0, 5)];
        end else if (r == 3) begin
          wr_left[i] = BL;
          req_addr[i*32 +: 32] = 32'h10000 + ($urandom_range(0, 15) << 8);
        end
      end
      req_read[i]  = rd_pend[i] != 0;
      req_write[i] = wr_left[i] > 0 &&
                     (wr_left[i] == BL || $urandom_range(0, 4) != 0);
      req_wdata[i*64 +: 64] = {$urandom, $urandom};
    end
    bmem_ready = $urandom_range(0, 3) != 0;
    if (m_tab.size() > 0 && $urandom_range(0, 1) == 1) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = m_tab[$urandom_range(0, m_tab.size() - 1)].a;
    end else begin
      bmem_rvalid = 1'b0;
      bmem_raddr  = $urandom;
    end
    bmem_rdata = {$urandom, $urandom};
  endtask

  initial begin
    rst_n = 1'b0;
    req_read = 2'b11; req_write = '0;
    req_addr = {32'h2000, 32'h1000};
    req_wdata = '0; bmem_ready = 1'b1;
    bmem_rvalid = 1'b1; bmem_raddr = 32'h1000; bmem_rdata = '1;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_rvalid", req_rvalid, 0);
    chk("rst_bread", bmem_read, 0);
    step();
    rst_n = 1'b1;
    idle();

    // Both read at once: r0 first, then r1
    step();
    req_addr = {32'h2000, 32'h1000};
    req_read = 2'b11;
    #1;
    chk("t1_gnt0", req_ready, 2'b01);
    chk("t1_addr0", bmem_addr, 32'h1000);
    step();
    req_read = 2'b10;
    #1;
    chk("t1_gnt1", req_ready, 2'b10);
    chk("t1_addr1", bmem_addr, 32'h2000);
    step();
    req_read = '0;

    // Out-of-order return: B then A
    for (int b = 0; b < BL; b++) begin
      step();
      bmem_rvalid = 1'b1; bmem_raddr = 32'h2000; bmem_rdata = 64'hB0 + b;
      #1;
      chk("t2_rv_b", req_rvalid, 2'b10);
      chk("t2_ra_b", req_raddr[63:32], 32'h2000);
      chk("t2_rd_b", req_rdata[127:64], 64'hB0 + b);
    end
    for (int b = 0; b < BL; b++) begin
      step();
      bmem_rvalid = 1'b1; bmem_raddr = 32'h1000; bmem_rdata = 64'hA0 + b;
      #1;
      chk("t2_rv_a", req_rvalid, 2'b01);
      chk("t2_ra_a", req_raddr[31:0], 32'h1000);
    end
    step();
    bmem_rvalid = 1'b0;

    // Write burst locks out r1's read
    step();
    req_addr = {32'h4000, 32'h3000};
    req_write = 2'b01; req_read = 2'b10;
    req_wdata = {64'h0, 64'hC0};
    #1;
    chk("t3_w0", req_ready, 2'b01);
    chk("t3_bw", bmem_write, 1'b1);
    for (int b = 1; b < BL; b++) begin
      step();
      req_wdata[63:0] = 64'hC0 + b;
      #1;
      chk("t3_wb", req_ready, 2'b01);
      chk("t3_wd", bmem_wdata, 64'hC0 + b);
    end
    step();
    req_write = '0;
    #1;
    chk("t3_r1", req_ready, 2'b10);
    chk("t3_brd", bmem_read, 1'b1);
    step();
    req_read = '0;

    // Fill the table, fifth read waits for a freeing beat
    for (int k = 0; k < 3; k++) begin
      step();
      req_addr[31:0] = 32'h5000 + (k << 12);
      req_read = 2'b01;
      #1;
      chk("t4_fill", req_ready, 2'b01);
    end
    step();
    req_addr[31:0] = 32'h8000;
    #1;
    chk("t4_full", req_ready, 2'b00);
    for (int b = 0; b < BL - 1; b++) begin
      step();
      bmem_rvalid = 1'b1; bmem_raddr = 32'h5000;
      #1;
      chk("t4_wait", req_ready, 2'b00);
    end
    step();
    #1;
    chk("t4_free", req_ready, 2'b01);
    chk("t4_rv", req_rvalid, 2'b01);
    step();
    idle();

    // Same-address read blocked until the owner's last beat
    ret(32'h4000);
    ret(32'h7000);
    step();
    req_addr[63:32] = 32'h6000;
    req_read = 2'b10;
    #1;
    chk("t5_blk", req_ready, 2'b00);
    for (int b = 0; b < BL - 1; b++) begin
      step();
      bmem_rvalid = 1'b1; bmem_raddr = 32'h6000;
      #1;
      chk("t5_blk_b", req_ready, 2'b00);
    end
    step();
    #1;
    chk("t5_go", req_ready, 2'b10);
    step();
    idle();
    ret(32'h8000);
    ret(32'h6000);

    // Reset during beat 2 of a burst
    step();
    req_addr[63:32] = 32'hA000;
    req_read = 2'b10;
    #1;
    chk("t6_rd", req_ready, 2'b10);
    step();
    req_read = '0;
    req_addr[31:0] = 32'h9000;
    req_write = 2'b01;
    #1;
    chk("t6_w0", req_ready, 2'b01);
    step();
    step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_bw", bmem_write, 1'b0);
    chk("t6_rdy", req_ready, 2'b00);
    step();
    rst_n = 1'b1;
    req_write = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      req_addr[31:0] = 32'hA000 + (k << 12);
      req_read = 2'b01;
      #1;
      chk("t6_empty", req_ready, 2'b01);
    end
    step();
    idle();
    for (int k = 0; k < 4; k++) ret(32'hA000 + (k << 12));

    // Randomized traffic with periodic resets
    for (int i = 0; i < N; i++) begin
      rd_pend[i] = 0;
      wr_left[i] = 0;
    end
    for (int c = 0; c < 4000; c++) begin
      step();
      if (c % 1000 == 999) begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
          rd_pend[i] = 0;
          wr_left[i] = 0;
        end
        idle();
      end else begin
        rst_n = 1'b1;
        rnd_cycle();
      end
    end
    step();
    rst_n = 1'b1;
    idle();
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
